snn_spike_aer_tx: RTL and testbench
===================================

// Module: snn_spike_aer_tx
// PURPOSE
//  Consumer-side partner of snn_core's event_vec/spikes_vec timestep interface.
//  - Accepts one N-bit spike vector per timestep.
//  - Serializes its set bits into an address-event (AER) stream: one beat per spike, then one end-of-tick beat.
//  - Replaces host-side CSV dumping of spikes_vec.
//  - Sits between snn_core output and the off-chip/host link.
// PARAMETERS
//  N    96          neurons per spike vector
//  TW   16          timestep counter / aer_ts width
//  IDW  $clog2(N)   neuron-index width (derived, not overridden)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rstn       in   1      synchronous, active-low reset
//  spk_valid  in   1      spk_vec holds a timestep's spikes
//  spk_ready  out  1      block can accept a vector
//  spk_vec    in   N      spike bits, bit n = neuron n
//  aer_valid  out  1      AER beat valid
//  aer_ready  in   1      downstream accepts beat
//  aer_id     out  IDW    neuron index of beat (0 on EOT beat)
//  aer_ts     out  TW     timestep of beat
//  aer_eot    out  1      beat is end-of-tick marker
//  busy       out  1      state != IDLE
//  tick_cnt   out  TW     completed-tick counter
// BEHAVIOUR
//  - Reset (rstn=0 at posedge):
//    - state=IDLE, pending=0, tick_cnt=0.
//    - aer_valid=0, aer_id=0, aer_ts=0, aer_eot=0, busy=0.
//    - spk_ready = rstn && state==IDLE, so it reads 0 while rstn is low.
//  - States:
//    - IDLE: spk_ready=1.
//      - On spk_valid&&spk_ready: pending<=spk_vec, aer_ts<=tick_cnt.
//      - Go to SCAN if spk_vec!=0, else to EOT.
//    - SCAN: aer_valid=1, aer_eot=0, aer_id = lowest set index of pending (ascending order).
//      - On aer_valid&&aer_ready: clear that bit.
//      - If no bits remain, go to EOT; else present the next-lowest index next cycle.
//    - EOT: aer_valid=1, aer_eot=1, aer_id=0.
//      - On handshake: tick_cnt<=tick_cnt+1 (mod 2^TW, wraps silently), go to IDLE.
//  - All aer_* outputs are registered. The first beat is valid the cycle after acceptance.
//  - With aer_ready held at 1, a tick with k spikes occupies k+2 cycles: k spike beats, 1 EOT, 1 IDLE accept.
//  - Handshake rules:
//    - While aer_valid && !aer_ready, aer_id/aer_ts/aer_eot stay stable; no beat is dropped or duplicated.
//    - aer_valid never deasserts without a handshake, except on reset.
//  - spk_ready=0 outside IDLE. Upstream holds spk_vec/spk_valid until accepted.
//  - spk_vec is sampled only at the accept edge; later changes are ignored.
//  - Reset mid-operation: pending is discarded, the partial tick is lost, and aer_valid drops at that edge.
//    The next accepted tick carries ts=0.
//  - The priority encoder over N bits is combinational from pending. The registered output bounds timing.
// CONFIGURATION
//  SNN_AER_SPKCNT_EN
//  - Defined:
//    - Adds output port aer_cnt [IDW:0].
//    - A counter increments on each SCAN handshake.
//    - aer_cnt = total spikes of the tick, presented on the EOT beat; 0 on spike beats.
//    - Counter clears on reset and on IDLE accept.
//  - Undefined: no port and no counter logic; all other behaviour is identical.
// TESTING
//  1. N=96, TW=16, aer_ready=1, vec with bits {3,17,95} after reset.
//     -> beats (id,ts,eot) = (3,0,0),(17,0,0),(95,0,0),(0,0,1); tick_cnt=1.
//     -> [EN] aer_cnt=3 on EOT.
//  2. vec=0 -> single EOT beat, ts=0; second vec=0 -> EOT ts=1; tick_cnt=2.
//  3. vec bits {5,17}; aer_ready=0 for 5 cycles while id=17 is presented.
//     -> id/ts/eot held, no extra beats, spk_ready=0 throughout; then 17, EOT.
//  4. vec all-ones -> 96 beats id 0..95 ascending, back-to-back one per cycle, then EOT.
//     -> [EN] aer_cnt=96.
//  5. TW=4, 17 zero vectors -> EOT ts sequence 0..15, then 0; tick_cnt wraps to 1.
//  6. vec bits {1,2,3}; rstn=0 for one cycle after beat id=1 handshakes.
//     -> aer_valid=0 the cycle after reset, tick_cnt=0.
//     -> next vec {7} gives beats (7,0,0),(0,0,1).

Source files
------------

// File: rtl/snn_spike_aer_tx.sv
// snn_spike_aer_tx: serializes one N-bit spike vector per timestep into an
// address-event stream. Each set bit becomes one beat, in ascending neuron
// order, and one end-of-tick (EOT) beat follows.
// Optional feature macro: SNN_AER_SPKCNT_EN adds aer_cnt, the spike total
// of the tick, which is presented on the EOT beat.
//
// Handshake semantics, used on both sides: a transfer happens on a posedge
// where valid && ready. A source that has raised valid keeps valid and its
// payload stable until that transfer; only reset may withdraw it.
module snn_spike_aer_tx #(
    parameter int N  = 96,
    parameter int TW = 16,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           spk_valid,
    output logic           spk_ready,
    input  logic [N-1:0]   spk_vec,
    output logic           aer_valid,
    input  logic           aer_ready,
    output logic [IDW-1:0] aer_id,
    output logic [TW-1:0]  aer_ts,
    output logic           aer_eot,
    output logic           busy,
    output logic [TW-1:0]  tick_cnt
`ifdef SNN_AER_SPKCNT_EN
    ,
    output logic [IDW:0]   aer_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EOT} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   pending, pending_nxt, pending_clr, enc_in;
    logic [IDW-1:0] enc_idx, id_nxt;
    logic [TW-1:0]  ts_nxt, tick_nxt;
    logic           valid_nxt, eot_nxt;
    logic           accept, beat;

    // Returns the lowest set index. Zero input returns 0, but callers never use that case.
    function automatic logic [IDW-1:0] lowest_set(input logic [N-1:0] v);
        logic [IDW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = IDW'(i);
        end
        return idx;
    endfunction

    assign spk_ready = rstn && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = spk_valid && spk_ready;
    assign beat      = aer_valid && aer_ready;

    // One shared priority encoder. In IDLE it sees the incoming vector.
    // Elsewhere it sees pending with the beat now on the bus already removed.
    always_comb begin
        pending_clr          = pending;
        pending_clr[aer_id]  = 1'b0;
        enc_in               = (state == S_IDLE) ? spk_vec : pending_clr;
        enc_idx              = lowest_set(enc_in);
    end

    // Next-state logic. It also computes the next registered AER beat, so the outputs stay glitch-free.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        valid_nxt   = aer_valid;
        id_nxt      = aer_id;
        ts_nxt      = aer_ts;
        eot_nxt     = aer_eot;
        tick_nxt    = tick_cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    pending_nxt = spk_vec;
                    ts_nxt      = tick_cnt;
                    valid_nxt   = 1'b1;
                    if (|spk_vec) begin
                        state_nxt = S_SCAN;
                        id_nxt    = enc_idx;
                        eot_nxt   = 1'b0;
                    end else begin
                        state_nxt = S_EOT;
                        id_nxt    = '0;
                        eot_nxt   = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (beat) begin
                    pending_nxt = pending_clr;
                    if (pending_clr == '0) begin
                        state_nxt = S_EOT;
                        id_nxt    = '0;
                        eot_nxt   = 1'b1;
                    end else begin
                        id_nxt    = enc_idx;
                    end
                end
            end
            S_EOT: begin
                if (beat) begin
                    state_nxt = S_IDLE;
                    tick_nxt  = tick_cnt + 1'b1;
                    valid_nxt = 1'b0;
                    id_nxt    = '0;
                    eot_nxt   = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and the registered datapath/outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            pending   <= '0;
            aer_valid <= 1'b0;
            aer_id    <= '0;
            aer_ts    <= '0;
            aer_eot   <= 1'b0;
            tick_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            aer_valid <= valid_nxt;
            aer_id    <= id_nxt;
            aer_ts    <= ts_nxt;
            aer_eot   <= eot_nxt;
            tick_cnt  <= tick_nxt;
        end
    end

`ifdef SNN_AER_SPKCNT_EN
    logic [IDW:0] spk_cnt;

    // Counts the spike beats of the current tick. It restarts when a new vector is accepted.
    always_ff @(posedge clk) begin
        if (!rstn || accept) begin
            spk_cnt <= '0;
        end else if (state == S_SCAN && beat) begin
            spk_cnt <= spk_cnt + 1'b1;
        end
    end

    assign aer_cnt = aer_eot ? spk_cnt : '0;
`endif

endmodule

// File: tb/tb_snn_spike_aer_tx.sv
// Self-checking bench for snn_spike_aer_tx.
// Main instance: N=96, TW=16. Second instance: N=8, TW=4, used for timestep wrap.
// Beats are packed as {cnt[7:0], eot, ts[15:0], id[6:0]}.
module tb_snn_spike_aer_tx;

    localparam int N  = 96;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          spk_valid = 1'b0;
    logic          spk_ready;
    logic [N-1:0]  spk_vec = '0;
    logic          aer_valid;
    logic          aer_ready = 1'b1;
    logic [6:0]    aer_id;
    logic [TW-1:0] aer_ts;
    logic          aer_eot;
    logic          busy;
    logic [TW-1:0] tick_cnt;

    logic          spk_valid4 = 1'b0;
    logic          spk_ready4;
    logic [7:0]    spk_vec4 = '0;
    logic          aer_valid4;
    logic          aer_ready4 = 1'b1;
    logic [2:0]    aer_id4;
    logic [3:0]    aer_ts4;
    logic          aer_eot4;
    logic          busy4;
    logic [3:0]    tick_cnt4;

    logic [7:0] cnt_val, cnt_val4;
`ifdef SNN_AER_SPKCNT_EN
    logic [7:0] aer_cnt;
    logic [3:0] aer_cnt4;
    assign cnt_val  = aer_cnt;
    assign cnt_val4 = 8'(aer_cnt4);
`else
    assign cnt_val  = 8'd0;
    assign cnt_val4 = 8'd0;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_q4[$];

    snn_spike_aer_tx #(.N(N), .TW(TW)) dut (
        .clk(clk), .rstn(rstn),
        .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_vec(spk_vec),
        .aer_valid(aer_valid), .aer_ready(aer_ready), .aer_id(aer_id),
        .aer_ts(aer_ts), .aer_eot(aer_eot), .busy(busy), .tick_cnt(tick_cnt)
`ifdef SNN_AER_SPKCNT_EN
        , .aer_cnt(aer_cnt)
`endif
    );

    snn_spike_aer_tx #(.N(8), .TW(4)) dut4 (
        .clk(clk), .rstn(rstn),
        .spk_valid(spk_valid4), .spk_ready(spk_ready4), .spk_vec(spk_vec4),
        .aer_valid(aer_valid4), .aer_ready(aer_ready4), .aer_id(aer_id4),
        .aer_ts(aer_ts4), .aer_eot(aer_eot4), .busy(busy4), .tick_cnt(tick_cnt4)
`ifdef SNN_AER_SPKCNT_EN
        , .aer_cnt(aer_cnt4)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: act=timeout req=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [31:0] mk_beat(input logic [6:0] id, input logic [15:0] ts,
                                            input logic eot, input logic [7:0] cnt);
`ifdef SNN_AER_SPKCNT_EN
        return {cnt, eot, ts, id};
`else
        return {8'd0 & cnt, eot, ts, id};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=%h req=%h at %0t", nm, act, req, $time);
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    // Pop one expected beat for every handshake seen, sampled on the falling edge.
    always @(negedge clk) begin
        if (rstn && aer_valid && aer_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", mk_beat(aer_id, aer_ts, aer_eot, cnt_val), 32'hffff_ffff);
            end else begin
                chk("beat", mk_beat(aer_id, aer_ts, aer_eot, cnt_val), exp_q.pop_front());
            end
        end
    end

    // Same scoreboard for the narrow instance.
    always @(negedge clk) begin
        if (rstn && aer_valid4 && aer_ready4) begin
            if (exp_q4.size() == 0) begin
                chk("unexpected_beat4", mk_beat(7'(aer_id4), 16'(aer_ts4), aer_eot4, cnt_val4),
                    32'hffff_ffff);
            end else begin
                chk("beat4", mk_beat(7'(aer_id4), 16'(aer_ts4), aer_eot4, cnt_val4),
                    exp_q4.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_tick(input logic [N-1:0] v, input logic [15:0] ts);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                exp_q.push_back(mk_beat(7'(i), ts, 1'b0, 8'd0));
                cnt++;
            end
        end
        exp_q.push_back(mk_beat(7'd0, ts, 1'b1, cnt));
    endtask

    // Returns at posedge+1 of the accept edge. Afterwards spk_vec is scrambled, because the DUT must ignore it then.
    task automatic send_vec(input logic [N-1:0] v);
        int n;
        n = 0;
        spk_vec   = v;
        spk_valid = 1'b1;
        @(negedge clk);
        while (!spk_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!spk_ready) chk("accept_timeout", 32'(spk_ready), 32'd1);
        @(posedge clk);
        #1;
        spk_valid = 1'b0;
        spk_vec   = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    logic [N-1:0] v;

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_spk_ready", 32'(spk_ready), 32'd0);
        chk("rst_aer_valid", 32'(aer_valid), 32'd0);
        chk("rst_outputs", mk_beat(aer_id, aer_ts, aer_eot, 8'd0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick_cnt", 32'(tick_cnt), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("idle_spk_ready", 32'(spk_ready), 32'd1);
        @(posedge clk);
        #1;

        // Test 1: bits {3,17,95}
        v = '0; v[3] = 1'b1; v[17] = 1'b1; v[95] = 1'b1;
        push_tick(v, 16'd0);
        send_vec(v);
        wait_idle();
        chk("t1_tick_cnt", 32'(tick_cnt), 32'd1);

        // Test 2: empty vectors give EOT only
        do_reset();
        chk("t2_tick_cnt_rst", 32'(tick_cnt), 32'd0);
        push_tick('0, 16'd0);
        send_vec('0);
        wait_idle();
        push_tick('0, 16'd1);
        send_vec('0);
        wait_idle();
        chk("t2_tick_cnt", 32'(tick_cnt), 32'd2);

        // Test 3: stall while id=17 is presented
        aer_ready = 1'b0;
        v = '0; v[5] = 1'b1; v[17] = 1'b1;
        push_tick(v, 16'd2);
        send_vec(v);
        aer_ready = 1'b1;           // lets beat 5 through on the next edge
        @(posedge clk);
        #1 aer_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", 32'(aer_valid), 32'd1);
            chk("t3_stall_beat", mk_beat(aer_id, aer_ts, aer_eot, 8'd0),
                mk_beat(7'd17, 16'd2, 1'b0, 8'd0));
            chk("t3_stall_spk_ready", 32'(spk_ready), 32'd0);
        end
        @(posedge clk);
        #1 aer_ready = 1'b1;
        wait_idle();
        chk("t3_tick_cnt", 32'(tick_cnt), 32'd3);

        // Test 4: all ones, back-to-back
        v = '1;
        push_tick(v, 16'd3);
        send_vec(v);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (busy && n < 300) begin
                n++;
                @(negedge clk);
            end
            chk("t4_busy_cycles", 32'(n), 32'd97);
        end
        wait_idle();
        chk("t4_tick_cnt", 32'(tick_cnt), 32'd4);

        // Test 6: reset after beat id=1 handshakes
        v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1;
        exp_q.push_back(mk_beat(7'd1, 16'd4, 1'b0, 8'd0));
        send_vec(v);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(aer_valid && aer_id == 7'd1) && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t6_first_beat", 32'(aer_id), 32'd1);
        end
        @(posedge clk);             // beat id=1 transfers here
        #1 rstn = 1'b0;
        chk("t6_q_before_rst", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        chk("t6_valid_after_rst", 32'(aer_valid), 32'd0);
        chk("t6_tick_after_rst", 32'(tick_cnt), 32'd0);
        chk("t6_busy_after_rst", 32'(busy), 32'd0);
        v = '0; v[7] = 1'b1;
        push_tick(v, 16'd0);
        send_vec(v);
        wait_idle();
        chk("t6_tick_cnt", 32'(tick_cnt), 32'd1);

        // Test 5: TW=4 wraps after 16 ticks
        for (int i = 0; i < 17; i++) begin
            exp_q4.push_back(mk_beat(7'd0, 16'(i % 16), 1'b1, 8'd0));
        end
        spk_valid4 = 1'b1;
        begin
            int n, guard;
            n = 0;
            guard = 0;
            while (n < 17 && guard < 200) begin
                @(negedge clk);
                guard++;
                if (spk_ready4) begin
                    n++;
                    if (n == 17) begin
                        @(posedge clk);
                        #1 spk_valid4 = 1'b0;
                    end
                end
            end
            chk("t5_accepts", 32'(n), 32'd17);
            guard = 0;
            @(negedge clk);
            while ((busy4 || exp_q4.size() != 0) && guard < 50) begin
                @(negedge clk);
                guard++;
            end
        end
        spk_valid4 = 1'b0;
        chk("t5_drain", 32'(exp_q4.size()), 32'd0);
        chk("t5_tick_cnt_wrap", 32'(tick_cnt4), 32'd1);

        chk("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
